// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - halfword SRAM responder with 32-bit pairing checker and sticky error flags
// Optional build macro: SRAM_RESPONDER_STATS_EN adds the read/write pair counters.
module sram_responder #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [17:0] SRAM_ADDR,
  input  logic [15:0] SRAM_D,
  output logic [15:0] SRAM_Q,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_OE_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_UB_N,
  input  logic        i_err_clr,
  output logic [2:0]  o_err,
  output logic        o_pair_done,
  output logic [15:0] o_rd_cnt,
  output logic [15:0] o_wr_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LO_RD = 2'd1,
    S_LO_WR = 2'd2
  } state_t;

  state_t state, state_nx;

  // Only the upper 17 bits of the even address are kept; the second half is always latched|1.
  logic [16:0] lat_hi, lat_hi_nx;

  logic [15:0] mem [DEPTH];

  logic                  active, is_wr, is_rd, is_conf, in_range, hit_odd;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  seq_err, rd_done, wr_done;
  logic [2:0]            err_set;

  assign active   = !SRAM_CE_N;
  assign is_wr    = active && !SRAM_WE_N;
  assign is_rd    = active && SRAM_WE_N && !SRAM_OE_N;
  assign is_conf  = is_wr && !SRAM_OE_N;
  assign in_range = (SRAM_ADDR >> DEPTH_LOG2) == 18'd0;
  assign idx      = SRAM_ADDR[DEPTH_LOG2-1:0];
  assign hit_odd  = (SRAM_ADDR == {lat_hi, 1'b1});
  assign wr_en    = is_wr && in_range && !i_reset;

  // Array write with per-byte lane enables; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_D[7:0];
      if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_D[15:8];
    end
  end

  // Zero-latency read data; disabled lanes and non-read cycles return zeros.
  always_comb begin
    SRAM_Q = 16'h0000;
    if (is_rd && in_range) begin
      SRAM_Q[7:0]  = SRAM_LB_N ? 8'h00 : mem[idx][7:0];
      SRAM_Q[15:8] = SRAM_UB_N ? 8'h00 : mem[idx][15:8];
    end
  end

  // Pairing next-state: an even halfword must be followed at once by the same op at the odd one.
  always_comb begin
    state_nx  = state;
    lat_hi_nx = lat_hi;
    seq_err   = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_rd || is_wr) begin
          if (!SRAM_ADDR[0]) begin
            lat_hi_nx = SRAM_ADDR[17:1];
            state_nx  = is_wr ? S_LO_WR : S_LO_RD;
          end else begin
            seq_err = 1'b1;
          end
        end
      end
      S_LO_RD: begin
        state_nx = S_IDLE;
        if (is_rd && hit_odd) rd_done = 1'b1;
        else                  seq_err = 1'b1;
      end
      S_LO_WR: begin
        state_nx = S_IDLE;
        if (is_wr && hit_odd) wr_done = 1'b1;
        else                  seq_err = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign err_set = {seq_err, active && !in_range, is_conf};

  // FSM, sticky error flags (set beats clear) and the completion pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      lat_hi      <= '0;
      o_err       <= 3'b000;
      o_pair_done <= 1'b0;
    end else begin
      state       <= state_nx;
      lat_hi      <= lat_hi_nx;
      o_err       <= (i_err_clr ? 3'b000 : o_err) | err_set;
      o_pair_done <= rd_done || wr_done;
    end
  end

`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;

  // Saturating completed-pair counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_cnt <= 16'h0000;
      wr_cnt <= 16'h0000;
    end else begin
      if (rd_done && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (wr_done && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign o_rd_cnt = rd_cnt;
  assign o_wr_cnt = wr_cnt;
`else
  assign o_rd_cnt = 16'h0000;
  assign o_wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - randomized and directed bench for sram_responder against a behavioural model
module tb_sram_responder;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [17:0] SRAM_ADDR = '0;
  logic [15:0] SRAM_D = '0;
  logic [15:0] SRAM_Q;
  logic        SRAM_CE_N = 1'b1;
  logic        SRAM_WE_N = 1'b1;
  logic        SRAM_OE_N = 1'b1;
  logic        SRAM_LB_N = 1'b1;
  logic        SRAM_UB_N = 1'b1;
  logic        i_err_clr = 1'b0;
  logic [2:0]  o_err;
  logic        o_pair_done;
  logic [15:0] o_rd_cnt;
  logic [15:0] o_wr_cnt;

  sram_responder #(.DEPTH_LOG2(12)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N),
    .i_err_clr(i_err_clr), .o_err(o_err), .o_pair_done(o_pair_done),
    .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt)
  );

  always #5 i_clk = ~i_clk;

  int vecs = 0;
  int miss = 0;

  // Behavioural model: the array, sticky errors, the pending half of a pair and pair tallies.
  logic [15:0] mem_m [4096];
  logic [2:0]  err_m;
  int          pend_m;
  logic [17:0] lat_m;
  bit          pd_m;
  int          rd_m, wr_m;

  function automatic logic [15:0] cnt_exp(input int c);
`ifdef SRAM_RESPONDER_STATS_EN
    return c[15:0];
`else
    return (c == -1) ? 16'h1 : 16'h0;
`endif
  endfunction

  function automatic logic [15:0] model_q();
    logic [15:0] q;
    logic [17:0] a;
    q = 16'h0000;
    a = SRAM_ADDR;
    if (!SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N && a < 18'd4096) begin
      if (!SRAM_LB_N) q[7:0]  = mem_m[a[11:0]][7:0];
      if (!SRAM_UB_N) q[15:8] = mem_m[a[11:0]][15:8];
    end
    return q;
  endfunction

  task automatic model_reset();
    err_m = 3'b000; pend_m = 0; pd_m = 0; rd_m = 0; wr_m = 0; lat_m = '0;
  endtask

  // Advance one clock: the model consumes the current bus, then outputs are sampled 1ns after the edge.
  task automatic tick();
    bit act, wr, rd, conf, inr;
    int op;
    logic [2:0] set;
    logic [17:0] a;
    a = SRAM_ADDR;
    act = !SRAM_CE_N;
    wr = act && !SRAM_WE_N;
    rd = act && SRAM_WE_N && !SRAM_OE_N;
    conf = wr && !SRAM_OE_N;
    inr = a < 18'd4096;
    set = 3'b000;
    if (conf) set[0] = 1'b1;
    if (act && !inr) set[1] = 1'b1;
    if (wr && inr) begin
      if (!SRAM_LB_N) mem_m[a[11:0]][7:0]  = SRAM_D[7:0];
      if (!SRAM_UB_N) mem_m[a[11:0]][15:8] = SRAM_D[15:8];
    end
    op = wr ? 2 : (rd ? 1 : 0);
    pd_m = 0;
    if (pend_m == 0) begin
      if (op != 0) begin
        if (a[0] == 1'b0) begin pend_m = op; lat_m = a; end
        else set[2] = 1'b1;
      end
    end else begin
      if (op == pend_m && a == (lat_m | 18'd1)) begin
        pd_m = 1;
        if (op == 1 && rd_m < 65535) rd_m++;
        if (op == 2 && wr_m < 65535) wr_m++;
      end else begin
        set[2] = 1'b1;
      end
      pend_m = 0;
    end
    err_m = (i_err_clr ? 3'b000 : err_m) | set;
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus(input bit ce_n, we_n, oe_n, lb_n, ub_n,
                     input logic [17:0] a, input logic [15:0] d, input bit clr);
    SRAM_CE_N = ce_n; SRAM_WE_N = we_n; SRAM_OE_N = oe_n;
    SRAM_LB_N = lb_n; SRAM_UB_N = ub_n;
    SRAM_ADDR = a; SRAM_D = d; i_err_clr = clr;
    #1;
  endtask

  task automatic clear_err();
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 1); tick();
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; #2; model_reset(); i_reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    vecs++; if (o_err !== 3'b000) begin miss++; $display("FAIL reset_err: got %b want 000", o_err); end
    vecs++; if (o_pair_done !== 1'b0) begin miss++; $display("FAIL reset_pd: got %b want 0", o_pair_done); end
    vecs++; if (o_rd_cnt !== 16'h0) begin miss++; $display("FAIL reset_rd: got %h want 0000", o_rd_cnt); end
    vecs++; if (o_wr_cnt !== 16'h0) begin miss++; $display("FAIL reset_wr: got %h want 0000", o_wr_cnt); end
    i_reset = 1'b0;
  endtask

  task automatic fill_window();
    for (int i = 0; i < 64; i++) begin
      bus(0, 0, 1, 0, 0, 18'(2 * i), 16'($urandom), 0); tick();
      bus(0, 0, 1, 0, 0, 18'(2 * i + 1), 16'($urandom), 0); tick();
    end
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0);
  endtask

  task automatic test_pair();
    bus(0, 0, 1, 0, 0, 18'h100, 16'hBEEF, 0); tick();
    bus(0, 0, 1, 0, 0, 18'h101, 16'hDEAD, 0); tick();
    vecs++; if (o_pair_done !== 1'b1) begin miss++; $display("FAIL pair_wr_pd: got %b want 1", o_pair_done); end
    vecs++; if (o_wr_cnt !== cnt_exp(1)) begin miss++; $display("FAIL pair_wr_cnt: got %h want %h", o_wr_cnt, cnt_exp(1)); end
    bus(0, 1, 0, 0, 0, 18'h100, 16'h0, 0);
    vecs++; if (SRAM_Q !== 16'hBEEF) begin miss++; $display("FAIL pair_rd_lo: got %h want BEEF", SRAM_Q); end
    tick();
    vecs++; if (o_pair_done !== 1'b0) begin miss++; $display("FAIL pair_rd_pd0: got %b want 0", o_pair_done); end
    bus(0, 1, 0, 0, 0, 18'h101, 16'h0, 0);
    vecs++; if (SRAM_Q !== 16'hDEAD) begin miss++; $display("FAIL pair_rd_hi: got %h want DEAD", SRAM_Q); end
    tick();
    vecs++; if (o_pair_done !== 1'b1) begin miss++; $display("FAIL pair_rd_pd: got %b want 1", o_pair_done); end
    vecs++; if (o_rd_cnt !== cnt_exp(1)) begin miss++; $display("FAIL pair_rd_cnt: got %h want %h", o_rd_cnt, cnt_exp(1)); end
    vecs++; if (o_err !== 3'b000) begin miss++; $display("FAIL pair_err: got %b want 000", o_err); end
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0); tick();
    vecs++; if (o_pair_done !== 1'b0) begin miss++; $display("FAIL pair_pd_once: got %b want 0", o_pair_done); end
  endtask

  task automatic test_lanes();
    bus(0, 0, 1, 0, 0, 18'h10, 16'h1234, 0); tick();
    bus(0, 0, 1, 0, 1, 18'h10, 16'hABCD, 0); tick();
    bus(0, 1, 0, 1, 0, 18'h10, 16'h0, 0);
    vecs++; if (SRAM_Q !== 16'h1200) begin miss++; $display("FAIL lanes_ub_only: got %h want 1200", SRAM_Q); end
    tick();
    bus(0, 1, 0, 0, 0, 18'h10, 16'h0, 0);
    vecs++; if (SRAM_Q !== 16'h12CD) begin miss++; $display("FAIL lanes_merged: got %h want 12CD", SRAM_Q); end
    tick();
    vecs++; if (o_err !== err_m) begin miss++; $display("FAIL lanes_err: got %b want %b", o_err, err_m); end
    clear_err();
  endtask

  task automatic test_conflict();
    vecs++; if (o_err !== 3'b000) begin miss++; $display("FAIL conf_pre_err: got %b want 000", o_err); end
    bus(0, 0, 0, 0, 0, 18'h20, 16'h5555, 0);
    vecs++; if (SRAM_Q !== 16'h0000) begin miss++; $display("FAIL conf_q: got %h want 0000", SRAM_Q); end
    tick();
    vecs++; if (o_err !== 3'b001) begin miss++; $display("FAIL conf_err: got %b want 001", o_err); end
    bus(0, 0, 1, 0, 0, 18'h21, 16'hAAAA, 1); tick();
    vecs++; if (o_err !== 3'b000) begin miss++; $display("FAIL conf_clr: got %b want 000", o_err); end
    vecs++; if (o_pair_done !== 1'b1) begin miss++; $display("FAIL conf_pair_pd: got %b want 1", o_pair_done); end
    bus(0, 1, 0, 0, 0, 18'h20, 16'h0, 0);
    vecs++; if (SRAM_Q !== 16'h5555) begin miss++; $display("FAIL conf_mem: got %h want 5555", SRAM_Q); end
    tick();
    bus(0, 1, 0, 0, 0, 18'h21, 16'h0, 0);
    vecs++; if (SRAM_Q !== 16'hAAAA) begin miss++; $display("FAIL conf_mem_hi: got %h want AAAA", SRAM_Q); end
    tick();
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0);
  endtask

  task automatic test_out_of_range();
    clear_err();
    bus(0, 0, 1, 0, 0, 18'h1000, 16'hFFFF, 0); tick();
    vecs++; if (o_err[1] !== 1'b1) begin miss++; $display("FAIL oor_err1: got %b want 1", o_err[1]); end
    vecs++; if (o_err !== err_m) begin miss++; $display("FAIL oor_err: got %b want %b", o_err, err_m); end
    bus(0, 1, 0, 0, 0, 18'h1000, 16'h0, 0);
    vecs++; if (SRAM_Q !== 16'h0000) begin miss++; $display("FAIL oor_rd_q: got %h want 0000", SRAM_Q); end
    tick();
    bus(0, 1, 0, 0, 0, 18'h0, 16'h0, 0);
    vecs++; if (SRAM_Q !== mem_m[0]) begin miss++; $display("FAIL oor_mem0: got %h want %h", SRAM_Q, mem_m[0]); end
    tick();
    bus(0, 1, 0, 0, 0, 18'h1, 16'h0, 0); tick();
    vecs++; if (o_err !== err_m) begin miss++; $display("FAIL oor_err_end: got %b want %b", o_err, err_m); end
    clear_err();
  endtask

  task automatic test_sequence();
    bus(0, 1, 0, 0, 0, 18'h40, 16'h0, 0); tick();
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0); tick();
    vecs++; if (o_err[2] !== 1'b1) begin miss++; $display("FAIL seq_idle_err: got %b want 1", o_err[2]); end
    vecs++; if (o_pair_done !== 1'b0) begin miss++; $display("FAIL seq_idle_pd: got %b want 0", o_pair_done); end
    vecs++; if (o_rd_cnt !== cnt_exp(rd_m)) begin miss++; $display("FAIL seq_rd_cnt: got %h want %h", o_rd_cnt, cnt_exp(rd_m)); end
    clear_err();
    bus(0, 1, 0, 0, 0, 18'h41, 16'h0, 0); tick();
    vecs++; if (o_err !== 3'b100) begin miss++; $display("FAIL seq_odd: got %b want 100", o_err); end
    clear_err();
  endtask

  task automatic test_reset_mid_pair();
    bus(0, 0, 1, 0, 0, 18'h30, 16'h7E81, 0); tick();
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0);
    i_reset = 1'b1; #1;
    model_reset();
    vecs++; if (o_err !== 3'b000) begin miss++; $display("FAIL rmid_err: got %b want 000", o_err); end
    vecs++; if (o_wr_cnt !== 16'h0) begin miss++; $display("FAIL rmid_wr: got %h want 0000", o_wr_cnt); end
    i_reset = 1'b0; #1;
    tick();
    vecs++; if (o_err !== 3'b000) begin miss++; $display("FAIL rmid_idle: got %b want 000", o_err); end
    vecs++; if (o_pair_done !== 1'b0) begin miss++; $display("FAIL rmid_pd: got %b want 0", o_pair_done); end
    bus(0, 1, 0, 0, 0, 18'h30, 16'h0, 0);
    vecs++; if (SRAM_Q !== 16'h7E81) begin miss++; $display("FAIL rmid_mem: got %h want 7E81", SRAM_Q); end
    tick();
    bus(0, 1, 0, 0, 0, 18'h31, 16'h0, 0); tick();
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0);
  endtask

  task automatic test_random();
    int kind;
    logic [17:0] a;
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      if (pend_m != 0 && $urandom_range(0, 3) != 0) begin
        a = lat_m | 18'd1;
        if ($urandom_range(0, 7) != 0) kind = (pend_m == 1) ? 3 : 7;
      end else if ($urandom_range(0, 15) == 0) begin
        a = 18'h1000 + 18'($urandom_range(0, 255));
      end else begin
        a = 18'($urandom_range(0, 127));
      end
      case (kind)
        0:       bus(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, a, 16'($urandom), 0);
        1:       bus(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), a, 16'($urandom), 0);
        2, 3, 4, 5: bus(0, 1, 0, $urandom_range(0, 1), $urandom_range(0, 1), a, 16'($urandom), 0);
        default: bus(0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1), a, 16'($urandom), 0);
      endcase
      i_err_clr = ($urandom_range(0, 7) == 0);
      vecs++; if (SRAM_Q !== model_q()) begin miss++; $display("FAIL rnd_q[%0d]: got %h want %h", n, SRAM_Q, model_q()); end
      tick();
      vecs++; if (o_err !== err_m) begin miss++; $display("FAIL rnd_err[%0d]: got %b want %b", n, o_err, err_m); end
      vecs++; if (o_pair_done !== pd_m) begin miss++; $display("FAIL rnd_pd[%0d]: got %b want %b", n, o_pair_done, pd_m); end
      vecs++; if (o_rd_cnt !== cnt_exp(rd_m)) begin miss++; $display("FAIL rnd_rd[%0d]: got %h want %h", n, o_rd_cnt, cnt_exp(rd_m)); end
      vecs++; if (o_wr_cnt !== cnt_exp(wr_m)) begin miss++; $display("FAIL rnd_wr[%0d]: got %h want %h", n, o_wr_cnt, cnt_exp(wr_m)); end
    end
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0);
  endtask

`ifdef SRAM_RESPONDER_STATS_EN
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      bus(0, 0, 1, 0, 0, 18'h50, 16'(i), 0); tick();
      bus(0, 0, 1, 0, 0, 18'h51, 16'(i), 0); tick();
    end
    vecs++; if (o_wr_cnt !== 16'hFFFF) begin miss++; $display("FAIL sat_full: got %h want FFFF", o_wr_cnt); end
    bus(0, 0, 1, 0, 0, 18'h50, 16'h1, 0); tick();
    bus(0, 0, 1, 0, 0, 18'h51, 16'h1, 0); tick();
    vecs++; if (o_wr_cnt !== 16'hFFFF) begin miss++; $display("FAIL sat_hold: got %h want FFFF", o_wr_cnt); end
    vecs++; if (o_pair_done !== 1'b1) begin miss++; $display("FAIL sat_pd: got %b want 1", o_pair_done); end
    bus(1, 1, 1, 1, 1, 18'h0, 16'h0, 0);
  endtask
`endif

  initial begin
    test_reset();
    @(posedge i_clk); #1;
    fill_window();
    do_reset();
    test_pair();
    test_lanes();
    test_conflict();
    test_out_of_range();
    test_sequence();
    test_reset_mid_pair();
    test_random();
`ifdef SRAM_RESPONDER_STATS_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
